// File: rtl/dt_pkg.sv
// Shared definitions for the distance-transform result-memory arbiter:
// default memory geometry, requester indices, lock-state encoding and
// small index helpers used by dt_res_arb and dt_rr_pick.
package dt_pkg;

  localparam int AW   = 14;  // 128x128 result map
  localparam int DW   = 8;   // distance value width
  localparam int NREQ = 3;

  localparam int REQ_FWD  = 0;  // forward pass
  localparam int REQ_BWD  = 1;  // backward pass
  localparam int REQ_HOST = 2;  // host dump

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Next requester index in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] rr_next_idx(input logic [1:0] i);
    case (i)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] idx_to_onehot(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    if (oh[1])      return 2'd1;
    else if (oh[2]) return 2'd2;
    else            return 2'd0;
  endfunction

endpackage

// File: rtl/dt_rr_pick.sv
// Three-way rotating-priority picker. The search starts at ptr and wraps
// around; only requesters that are both requesting and unmasked are
// eligible. Output is one-hot or zero.
module dt_rr_pick
  import dt_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] gnt
);

  logic [NREQ-1:0] elig;

  // First eligible requester at or after ptr, wrapping modulo 3.
  always_comb begin
    gnt  = '0;
    elig = req & mask;
    case (ptr)
      2'd1: begin
        if (elig[1])      gnt = 3'b010;
        else if (elig[2]) gnt = 3'b100;
        else if (elig[0]) gnt = 3'b001;
      end
      2'd2: begin
        if (elig[2])      gnt = 3'b100;
        else if (elig[0]) gnt = 3'b001;
        else if (elig[1]) gnt = 3'b010;
      end
      default: begin
        if (elig[0])      gnt = 3'b001;
        else if (elig[1]) gnt = 3'b010;
        else if (elig[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/dt_res_arb.sv
// Result-memory arbiter for the distance-transform engine. Three
// requesters (forward pass, backward pass, host dump) share one
// synchronous result memory. Arbitration is round-robin when the macro
// DT_ARB_RR_EN is defined, otherwise fixed priority 0 > 1 > 2 with the
// pointer held at 0. A requester may hold the bus with lock for up to
// LOCK_MAX consecutive transfers. Read data returns two cycles after the
// accept, tagged by a two-stage requester-ID pipeline.
module dt_res_arb
  import dt_pkg::lock_state_e, dt_pkg::FREE, dt_pkg::LOCKED,
         dt_pkg::rr_next_idx, dt_pkg::idx_to_onehot, dt_pkg::onehot_to_idx;
#(
  parameter int AW       = dt_pkg::AW,
  parameter int DW       = dt_pkg::DW,
  parameter int LOCK_MAX = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [2:0]      lock,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            res_wr,
  output logic            res_rd,
  output logic [AW-1:0]   res_addr,
  output logic [DW-1:0]   res_do,
  input  logic [DW-1:0]   res_di
);

  // Lock-run counter increment that sticks at all-ones.
  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'h1F) ? v : v + 5'd1;
  endfunction

  lock_state_e state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  owner_q, owner_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [2:0]    pick_mask;
  logic [2:0]    pick_gnt;
  logic          acc_any;
  logic [1:0]    acc_idx;
  logic          acc_we;
  logic          acc_lock;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  logic       vld_p1, vld_p2;
  logic [1:0] rid_p1, rid_p2;

  // While locked only the owner is eligible, even when it is idle.
  always_comb begin
    pick_mask = 3'b111;
    if (state_q == LOCKED) pick_mask = idx_to_onehot(owner_q);
  end

  dt_rr_pick u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .mask (pick_mask),
    .gnt  (pick_gnt)
  );

  // Grant is combinational and forced low while reset is held.
  always_comb begin
    gnt       = reset ? pick_gnt : 3'b000;
    acc_any   = |gnt;
    acc_idx   = onehot_to_idx(gnt);
    acc_we    = we[acc_idx];
    acc_lock  = lock[acc_idx];
    acc_addr  = addr[int'(acc_idx) * AW +: AW];
    acc_wdata = wdata[int'(acc_idx) * DW +: DW];
  end

  // Lock FSM next state, owner, run counter and round-robin pointer.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      FREE: begin
        if (acc_any) begin
          if (acc_lock && (LOCK_MAX > 1)) begin
            state_d = LOCKED;
            owner_d = acc_idx;
            cnt_d   = 5'd1;
          end else begin
`ifdef DT_ARB_RR_EN
            ptr_d = rr_next_idx(acc_idx);
`endif
          end
        end
      end
      LOCKED: begin
        // The owner leaves by an unlocked transfer, by going fully idle,
        // or by exhausting its run length even if lock stays high.
        if ((acc_any && (!acc_lock || (32'(cnt_q) + 1 >= LOCK_MAX))) ||
            (!acc_any && !req[owner_q] && !lock[owner_q])) begin
          state_d = FREE;
          cnt_d   = 5'd0;
`ifdef DT_ARB_RR_EN
          ptr_d = rr_next_idx(owner_q);
`endif
        end else if (acc_any) begin
          cnt_d = sat_inc5(cnt_q);
        end
      end
      default: begin
        state_d = FREE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FREE;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- stage p1: memory command register, one cycle after accept ----
  // Strobes pulse per accept; address and write data hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_wr   <= 1'b0;
      res_rd   <= 1'b0;
      res_addr <= '0;
      res_do   <= '0;
    end else begin
      res_wr <= acc_any & acc_we;
      res_rd <= acc_any & ~acc_we;
      if (acc_any) begin
        res_addr <= acc_addr;
        res_do   <= acc_wdata;
      end
    end
  end

  // Requester ID travels with the read so mixed back-to-back reads return
  // to the right owner; reset drops anything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      rid_p1 <= 2'd0;
      vld_p2 <= 1'b0;
      rid_p2 <= 2'd0;
    end else begin
      vld_p1 <= acc_any & ~acc_we;
      rid_p1 <= acc_idx;
      // ---- stage p2: memory data returns, read response cycle ----
      vld_p2 <= vld_p1;
      rid_p2 <= rid_p1;
    end
  end

  // Read response: memory data passes through in the cycle it is valid.
  always_comb begin
    rvalid = 3'b000;
    rdata  = '0;
    if (vld_p2) begin
      rvalid = idx_to_onehot(rid_p2);
      rdata  = res_di;
    end
  end

endmodule

// File: tb/tb_dt_res_arb.sv
// Self-checking bench for dt_res_arb: table of grant vectors, directed
// multi-cycle sequences and randomized traffic, all checked against a
// behavioural model of the arbitration rules and a golden memory image.
module tb_dt_res_arb;

  localparam int AW       = 14;
  localparam int DW       = 8;
  localparam int LOCK_MAX = 16;
`ifdef DT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [2:0]      req = '0, we = '0, lock = '0;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            res_wr, res_rd;
  logic [AW-1:0]   res_addr;
  logic [DW-1:0]   res_do;
  logic [DW-1:0]   res_di;

  always #5 clk = ~clk;

  dt_res_arb #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .res_wr(res_wr), .res_rd(res_rd), .res_addr(res_addr), .res_do(res_do),
    .res_di(res_di)
  );

  // Synchronous result memory attached to the arbiter.
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (res_wr) env_mem[res_addr] <= res_do;
    if (res_rd) res_di <= env_mem[res_addr];
  end

  // Reference model state.
  logic [DW-1:0] gold [0:(1<<AW)-1];
  int m_ptr, m_owner, m_cnt;
  bit m_locked;
  logic          e_wr, e_rd;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_do;
  typedef struct { int due; int id; logic [DW-1:0] data; } rd_t;
  rd_t rq[$];
  int cyc = 0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [2:0] req; logic [2:0] exp_rr; logic [2:0] exp_fp; } tv_t;
  tv_t tbl[10];

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 7 + 3);
  endfunction

  function automatic logic [3*AW-1:0] pa(input int a0, input int a1, input int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [3*DW-1:0] pd(input int d0, input int d1, input int d2);
    return {DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 1'b0;
    e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_do = '0;
    rq.delete();
  endtask

  task automatic model_release();
    m_locked = 1'b0;
    m_cnt = 0;
    if (RR) m_ptr = (m_owner + 1) % 3;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check grant,
  // then advance the model to what the next cycle should show.
  task automatic step(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                      input logic [3*AW-1:0] a, input logic [3*DW-1:0] d,
                      output logic [2:0] g);
    int win, p;
    logic [2:0] eg;
    @(negedge clk);
    cyc++;
    chk("res_wr", 32'(res_wr), 32'(e_wr));
    chk("res_rd", 32'(res_rd), 32'(e_rd));
    chk("res_addr", 32'(res_addr), 32'(e_addr));
    chk("res_do", 32'(res_do), 32'(e_do));
    if (rq.size() > 0 && rq[0].due == cyc) begin
      chk("rvalid", 32'(rvalid), 32'(1 << rq[0].id));
      chk("rdata", 32'(rdata), 32'(rq[0].data));
      void'(rq.pop_front());
    end else begin
      chk("rvalid_idle", 32'(rvalid), 32'(0));
    end
    req = r; we = w; lock = l; addr = a; wdata = d;
    #1;
    win = -1;
    if (m_locked) begin
      if (r[m_owner]) win = m_owner;
    end else begin
      p = RR ? m_ptr : 0;
      for (int k = 0; k < 3; k++)
        if (win < 0 && r[(p + k) % 3]) win = (p + k) % 3;
    end
    eg = (win < 0) ? 3'b000 : 3'(1 << win);
    chk("gnt", 32'(gnt), 32'(eg));
    g = gnt;
    e_wr = 1'b0; e_rd = 1'b0;
    if (win >= 0) begin
      e_addr = a[win*AW +: AW];
      e_do   = d[win*DW +: DW];
      if (w[win]) begin
        e_wr = 1'b1;
        gold[e_addr] = e_do;
      end else begin
        e_rd = 1'b1;
        rq.push_back('{due: cyc + 2, id: win, data: gold[e_addr]});
      end
      if (!m_locked) begin
        if (l[win] && LOCK_MAX > 1) begin
          m_locked = 1'b1; m_owner = win; m_cnt = 1;
        end else if (RR) begin
          m_ptr = (win + 1) % 3;
        end
      end else begin
        m_cnt++;
        if (!l[win] || m_cnt >= LOCK_MAX) model_release();
      end
    end else if (m_locked && !r[m_owner] && !l[m_owner]) begin
      model_release();
    end
  endtask

  task automatic idle(input int n);
    logic [2:0] g;
    for (int i = 0; i < n; i++) step(3'b000, 3'b000, 3'b000, '0, '0, g);
  endtask

  // Assert reset with all requesters active; grant and outputs must be low.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req = 3'b111; we = 3'b000; lock = 3'b111;
    model_reset();
    #1;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_res_wr", 32'(res_wr), 32'(0));
    chk("rst_res_rd", 32'(res_rd), 32'(0));
    chk("rst_res_addr", 32'(res_addr), 32'(0));
    chk("rst_res_do", 32'(res_do), 32'(0));
    chk("rst_rvalid", 32'(rvalid), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    repeat (2) @(negedge clk);
    req = '0; lock = '0;
    reset = 1'b1;
  endtask

  initial begin
    logic [2:0] g;
    logic [2:0] ga [3];
    int cnt0;

    for (int i = 0; i < (1 << AW); i++) begin
      env_mem[i] = init_val(i);
      gold[i]    = init_val(i);
    end

    tbl[0] = '{3'b000, 3'b000, 3'b000};
    tbl[1] = '{3'b110, 3'b010, 3'b010};
    tbl[2] = '{3'b111, 3'b100, 3'b001};
    tbl[3] = '{3'b111, 3'b001, 3'b001};
    tbl[4] = '{3'b101, 3'b100, 3'b001};
    tbl[5] = '{3'b011, 3'b001, 3'b001};
    tbl[6] = '{3'b011, 3'b010, 3'b001};
    tbl[7] = '{3'b001, 3'b001, 3'b001};
    tbl[8] = '{3'b100, 3'b100, 3'b100};
    tbl[9] = '{3'b010, 3'b010, 3'b010};

    do_reset();

    // Grant sequence from the reset pointer, all reads.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].req, 3'b000, 3'b000, pa(20 + i, 40 + i, 60 + i), '0, g);
      chk($sformatf("tbl_gnt[%0d]", i), 32'(g), 32'(RR ? tbl[i].exp_rr : tbl[i].exp_fp));
    end
    idle(3);

    // All three read addresses 5/6/7 at once.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(3'b111, 3'b000, 3'b000, pa(5, 6, 7), '0, ga[i]);
      chk($sformatf("rr3_gnt[%0d]", i), 32'(ga[i]),
          RR ? 32'(1 << i) : 32'(1));
    end
    chk("rr3_rvalid0", 32'(rvalid), 32'(3'b001));
    chk("rr3_rdata0", 32'(rdata), 32'(8'h26));
    step(3'b000, 3'b000, 3'b000, '0, '0, g);
    chk("rr3_rvalid1", 32'(rvalid), RR ? 32'(3'b010) : 32'(3'b001));
    chk("rr3_rdata1", 32'(rdata), RR ? 32'(8'h2D) : 32'(8'h26));
    step(3'b000, 3'b000, 3'b000, '0, '0, g);
    chk("rr3_rvalid2", 32'(rvalid), RR ? 32'(3'b100) : 32'(3'b001));
    chk("rr3_rdata2", 32'(rdata), RR ? 32'(8'h34) : 32'(8'h26));
    idle(2);

    // Write then read-back of the same address from another requester.
    do_reset();
    step(3'b010, 3'b010, 3'b000, pa(0, 130, 0), pd(0, 8'h04, 0), g);
    chk("wr130_gnt", 32'(g), 32'(3'b010));
    step(3'b100, 3'b000, 3'b000, pa(0, 0, 130), '0, g);
    chk("rd130_gnt", 32'(g), 32'(3'b100));
    step(3'b000, 3'b000, 3'b000, '0, '0, g);
    step(3'b000, 3'b000, 3'b000, '0, '0, g);
    chk("rd130_rvalid", 32'(rvalid), 32'(3'b100));
    chk("rd130_rdata", 32'(rdata), 32'(8'h04));
    idle(2);

    // Locked run is cut off after LOCK_MAX transfers.
    do_reset();
    cnt0 = 0;
    for (int i = 0; i < LOCK_MAX; i++) begin
      step(3'b011, 3'b000, 3'b001, pa(100 + i, 200, 0), '0, g);
      if (g == 3'b001) cnt0++;
    end
    chk("lock_accepts", 32'(cnt0), 32'(LOCK_MAX));
    step(3'b011, 3'b000, 3'b001, pa(300, 200, 0), '0, g);
    chk("lock_forced_release_gnt", 32'(g), RR ? 32'(3'b010) : 32'(3'b001));
    idle(3);

    // Owner goes idle with lock low for one cycle: lock is dropped.
    do_reset();
    step(3'b001, 3'b000, 3'b001, pa(11, 0, 0), '0, g);
    chk("own_enter_gnt", 32'(g), 32'(3'b001));
    step(3'b100, 3'b000, 3'b000, pa(0, 0, 12), '0, g);
    chk("own_masked_gnt", 32'(g), 32'(3'b000));
    step(3'b101, 3'b000, 3'b001, pa(13, 0, 12), '0, g);
    chk("own_release_gnt", 32'(g), RR ? 32'(3'b100) : 32'(3'b001));
    idle(3);

    // Requesters 1 and 2 held high together.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(3'b110, 3'b000, 3'b000, pa(0, 50, 51), '0, g);
      chk($sformatf("hold110_gnt[%0d]", i), 32'(g),
          (RR && (i % 2 == 1)) ? 32'(3'b100) : 32'(3'b010));
    end
    idle(3);

    // Reset arrives while a read is in flight.
    do_reset();
    step(3'b001, 3'b000, 3'b000, pa(9, 0, 0), '0, g);
    chk("midrd_gnt", 32'(g), 32'(3'b001));
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    model_reset();
    #1;
    chk("midrd_rvalid_rst", 32'(rvalid), 32'(0));
    chk("midrd_addr_rst", 32'(res_addr), 32'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(3'b000, 3'b000, 3'b000, '0, '0, g);
      chk($sformatf("midrd_rvalid[%0d]", i), 32'(rvalid), 32'(0));
      chk($sformatf("midrd_addr[%0d]", i), 32'(res_addr), 32'(0));
    end

    // Randomized traffic with phases of no, random and persistent locking.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [2:0] r, w, l;
      int mode;
      mode = (i / 40) % 3;
      r = 3'($urandom_range(0, 7));
      w = 3'($urandom_range(0, 7));
      case (mode)
        0:       l = 3'b000;
        1:       l = 3'($urandom_range(0, 7));
        default: l = 3'b111;
      endcase
      step(r, w, l,
           pa($urandom_range(0, 15), ($urandom_range(0, 3) == 0) ? 130 : $urandom_range(0, 15),
              $urandom_range(0, 15)),
           pd($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)), g);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
